timer_capture: RTL and testbench
================================

Name: timer_capture

Overview:
- Pulse-width capture unit. It is the measuring counterpart of the digital one-shot timer.
- The one-shot timer turns a programmed cycle count into a delayed event. This block turns an observed input pulse back into a cycle count.
- It sits beside the timer in the peripheral block and is used to measure external handshake and strobe durations.
- Results are handed to the core through a valid/ack handshake.

Parameters:
- WIDTH, 32: width of the cycle counter and of capture_val.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- arm  input  1  one-cycle pulse that starts a new measurement.
- pulse_in  input  1  signal whose high time is measured.
- capture_ack  input  1  consumer accepts the current result.
- capture_val  output  WIDTH  measured high time, in clk cycles.
- capture_valid  output  1  capture_val and capture_ovf are valid.
- capture_ovf  output  1  the count saturated during the measurement.
- busy  output  1  high in ARMED or MEASURING.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - capture_val = 0, capture_valid = 0, capture_ovf = 0, busy = 0.
  - Internal count = 0, pulse_q = 0.
- pulse_s is the sampled input: pulse_in directly, or its synchronized version (see Optional Feature).
- pulse_q is pulse_s delayed by one cycle. It is updated every cycle in every state.
- rise = pulse_s & ~pulse_q.
- State machine:
  - IDLE:
    - arm=1 -> ARMED; count <= 0.
  - ARMED:
    - rise=1 -> MEASURING; count <= 1.
    - If pulse_s is already high when armed, the block waits for a low and then a new rising edge. A pulse in progress is never measured.
  - MEASURING:
    - pulse_s=1: count <= count+1, saturating at 2^WIDTH-1. The cycle that would wrap sets an internal ovf flag, and count holds at all-ones.
    - pulse_s=0 -> DONE. capture_val <= count, capture_ovf <= ovf, capture_valid <= 1, all registered on the same edge.
  - DONE:
    - capture_ack=1 -> IDLE; capture_valid <= 0. capture_val and capture_ovf hold their last values.
    - arm=1 -> ARMED; capture_valid <= 0; the result is discarded.
- Result value: capture_val equals the number of consecutive cycles pulse_s was sampled high. This is the inverse of the timer: a timer programmed with N produces an N-cycle span, and capturing that span yields N.
- Latency: capture_valid rises on the clock edge after the first cycle pulse_s is sampled low.
- arm while ARMED or MEASURING:
  - Restarts the measurement: -> ARMED, count <= 0, ovf <= 0.
  - A rise in that same cycle is ignored.
- Simultaneous arm and capture_ack in DONE: arm wins (-> ARMED).
- capture_ack outside DONE is ignored.
- busy is a registered decode of the state: 1 iff state is ARMED or MEASURING.
- Reset mid-measurement: everything returns to reset values immediately, and no capture_valid is produced.
- Arithmetic: count is WIDTH bits, unsigned. Saturation is at all-ones; the counter never wraps.

Optional Feature:
- Macro: TIMER_CAPTURE_SYNC_EN.
- Defined:
  - pulse_in passes through a two-flop synchronizer, reset to 0, to form pulse_s. It may then be fully asynchronous to clk.
  - Every edge of pulse_in reaches pulse_s two cycles later, so the rise and fall reactions occur two cycles later.
  - The measured width is unchanged for a synchronous input.
- Undefined:
  - pulse_s = pulse_in. pulse_in must be synchronous to clk, with zero added latency.
- The bench runs with both settings and adjusts expected edge timing by 2 cycles.

Test Plan:
- Basic: reset, arm, 3 idle cycles, pulse_in high for 5 cycles then low -> capture_valid=1 with capture_val=5, capture_ovf=0, busy=0; ack returns to IDLE with capture_valid=0.
- Pre-high input: pulse_in held high, arm, keep high 10 cycles, low 2 cycles, high 7 cycles, low -> capture_val=7 (the first pulse is ignored).
- Saturation: WIDTH=8, arm, pulse high 300 cycles -> capture_val=255, capture_ovf=1. Re-arm, 1-cycle pulse -> capture_val=1, capture_ovf=0.
- Handshake hold and priority:
  - After capture_val=4, withhold ack 20 cycles -> capture_valid and value remain stable.
  - Assert arm and capture_ack together -> state ARMED, capture_valid=0, next 9-cycle pulse gives 9.
- Restart and reset:
  - arm, pulse high 6 cycles, arm again mid-pulse, pulse ends -> no result; the next full 3-cycle pulse gives 3.
  - Separately, drop rst during MEASURING -> all outputs 0 immediately, no capture_valid afterwards without a new arm.
- Timer loopback: drive pulse_in from the one-shot timer's output span for N in {1, 2, 4095, 65535} -> capture_val=N each time.

Source files
------------

// File: rtl/timer_capture.sv
// Pulse-width capture: measures how many clk cycles an input stays high and hands
// the result over a valid/ack handshake. Define TIMER_CAPTURE_SYNC_EN to synchronize pulse_in_i.
module timer_capture #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             arm_i,
  input  logic             pulse_in_i,
  input  logic             capture_ack_i,
  output logic [WIDTH-1:0] capture_val_o,
  output logic             capture_valid_o,
  output logic             capture_ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StMeasuring, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             ovf_q, ovf_d;
  logic             cap_ovf_q, cap_ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             pulse_s, pulse_q, rise;

`ifdef TIMER_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pulse_in_i};
    end
  end

  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulse_in_i;
`endif

  // Only a fresh edge starts a measurement; a pulse already high when armed is skipped.
  assign rise = pulse_s & ~pulse_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    val_d     = val_q;
    cap_ovf_d = cap_ovf_q;
    valid_d   = valid_q;
    case (state_q)
      StIdle: begin
        if (arm_i) begin
          state_d = StArmed;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StArmed: begin
        if (arm_i) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (rise) begin
          state_d = StMeasuring;
          count_d = WIDTH'(1);
        end
      end
      StMeasuring: begin
        if (arm_i) begin
          state_d = StArmed;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (pulse_s) begin
          // Saturate at all-ones rather than wrap.
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          state_d   = StDone;
          val_d     = count_q;
          cap_ovf_d = ovf_q;
          valid_d   = 1'b1;
        end
      end
      StDone: begin
        if (arm_i) begin
          state_d = StArmed;
          valid_d = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (capture_ack_i) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StArmed) || (state_d == StMeasuring);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      val_q     <= '0;
      cap_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      val_q     <= val_d;
      cap_ovf_q <= cap_ovf_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      pulse_q   <= pulse_s;
    end
  end

  assign capture_val_o   = val_q;
  assign capture_valid_o = valid_q;
  assign capture_ovf_o   = cap_ovf_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_timer_capture.sv
// Scoreboard bench for timer_capture: a 32-bit and an 8-bit instance share stimulus;
// expected results are queued per instance when a pulse is driven.
module tb_timer_capture;

`ifdef TIMER_CAPTURE_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        arm_i = 1'b0;
  logic        pulse_in_i = 1'b0;
  logic        capture_ack_i = 1'b0;
  logic [31:0] capture_val_o;
  logic        capture_valid_o, capture_ovf_o, busy_o;
  logic [7:0]  val8;
  logic        valid8, ovf8, busy8;

  int errors = 0;
  int checks = 0;

  logic [32:0] q32[$];
  logic [8:0]  q8[$];
  logic [32:0] exp32;
  logic [8:0]  exp8;
  logic        prev32 = 1'b0;
  logic        prev8 = 1'b0;

  always #5 clk_i = ~clk_i;

  timer_capture #(.WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .arm_i          (arm_i),
    .pulse_in_i     (pulse_in_i),
    .capture_ack_i  (capture_ack_i),
    .capture_val_o  (capture_val_o),
    .capture_valid_o(capture_valid_o),
    .capture_ovf_o  (capture_ovf_o),
    .busy_o         (busy_o)
  );

  timer_capture #(.WIDTH(8)) dut8 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .arm_i          (arm_i),
    .pulse_in_i     (pulse_in_i),
    .capture_ack_i  (capture_ack_i),
    .capture_val_o  (val8),
    .capture_valid_o(valid8),
    .capture_ovf_o  (ovf8),
    .busy_o         (busy8)
  );

  // Scoreboard: each rising capture_valid pops one expected result.
  always @(negedge clk_i) begin
    if (capture_valid_o && !prev32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL w32_unexpected_valid: val=%0d ovf=%0b, nothing expected", capture_val_o,
                 capture_ovf_o);
      end else begin
        exp32 = q32.pop_front();
        if ({capture_ovf_o, capture_val_o} !== exp32) begin
          errors++;
          $display("FAIL w32_result: got val=%0d ovf=%0b, want val=%0d ovf=%0b", capture_val_o,
                   capture_ovf_o, exp32[31:0], exp32[32]);
        end
      end
    end
    prev32 = capture_valid_o;
  end

  always @(negedge clk_i) begin
    if (valid8 && !prev8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_valid: val=%0d ovf=%0b, nothing expected", val8, ovf8);
      end else begin
        exp8 = q8.pop_front();
        if ({ovf8, val8} !== exp8) begin
          errors++;
          $display("FAIL w8_result: got val=%0d ovf=%0b, want val=%0d ovf=%0b", val8, ovf8,
                   exp8[7:0], exp8[8]);
        end
      end
    end
    prev8 = valid8;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input int unsigned n);
    q32.push_back({1'b0, n});
    q8.push_back((n > 255) ? 9'h1ff : {1'b0, n[7:0]});
  endtask

  task automatic arm_once();
    arm_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
  endtask

  // Stands in for the one-shot timer: an n-cycle high span on pulse_in.
  task automatic drive_pulse(input int n);
    pulse_in_i = 1'b1;
    tick(n);
    pulse_in_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick(1);
      if (capture_valid_o) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: capture_valid low after 20 cycles, want high", name);
    end else if (lat != Lat + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, Lat + 1);
    end
  endtask

  task automatic do_ack(input string name);
    capture_ack_i = 1'b1;
    tick(1);
    capture_ack_i = 1'b0;
    checks++;
    if ({capture_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s_ack: got valid=%0b busy=%0b, want 0 0", name, capture_valid_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(2);
    checks++;
    if ({capture_val_o, capture_valid_o, capture_ovf_o, busy_o, val8, valid8, ovf8, busy8} !== '0)
    begin
      errors++;
      $display("FAIL reset_outputs: got val=%0d valid=%0b ovf=%0b busy=%0b, want all 0",
               capture_val_o, capture_valid_o, capture_ovf_o, busy_o);
    end
    rst_ni = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    arm_once();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_armed: got %0b, want 1", busy_o);
    end
    tick(3);
    push_exp(5);
    drive_pulse(5);
    wait_valid("basic");
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done: got %0b, want 0", busy_o);
    end
    do_ack("basic");
  endtask

  task automatic test_pre_high();
    pulse_in_i = 1'b1;
    tick(4);
    arm_once();
    tick(9);
    pulse_in_i = 1'b0;
    tick(2);
    push_exp(7);
    drive_pulse(7);
    wait_valid("pre_high");
    do_ack("pre_high");
  endtask

  task automatic test_saturation();
    arm_once();
    tick(2);
    push_exp(300);
    drive_pulse(300);
    wait_valid("sat");
    do_ack("sat");
    arm_once();
    tick(2);
    push_exp(1);
    drive_pulse(1);
    wait_valid("sat_rearm");
    do_ack("sat_rearm");
  endtask

  task automatic test_handshake();
    arm_once();
    tick(2);
    push_exp(4);
    drive_pulse(4);
    wait_valid("hold");
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (capture_valid_o !== 1'b1 || capture_val_o !== 32'd4) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got valid=%0b val=%0d, want 1 4", i,
                 capture_valid_o, capture_val_o);
      end
    end
    arm_i = 1'b1;
    capture_ack_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
    capture_ack_i = 1'b0;
    checks++;
    if ({capture_valid_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL arm_ack_priority: got valid=%0b busy=%0b, want 0 1", capture_valid_o,
               busy_o);
    end
    tick(2);
    push_exp(9);
    drive_pulse(9);
    wait_valid("prio");
    do_ack("prio");
  endtask

  task automatic test_restart();
    arm_once();
    tick(2);
    pulse_in_i = 1'b1;
    tick(3);
    arm_once();
    tick(2);
    pulse_in_i = 1'b0;
    tick(8);
    checks++;
    if ({capture_valid_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL restart_no_result: got valid=%0b busy=%0b, want 0 1", capture_valid_o,
               busy_o);
    end
    push_exp(3);
    drive_pulse(3);
    wait_valid("restart");
    do_ack("restart");
  endtask

  task automatic test_reset_mid();
    arm_once();
    tick(2);
    pulse_in_i = 1'b1;
    tick(4);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({capture_val_o, capture_valid_o, capture_ovf_o, busy_o} !== '0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got val=%0d valid=%0b ovf=%0b busy=%0b, want all 0",
               capture_val_o, capture_valid_o, capture_ovf_o, busy_o);
    end
    tick(1);
    rst_ni = 1'b1;
    tick(3);
    pulse_in_i = 1'b0;
    tick(10);
    checks++;
    if ({capture_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_quiet: got valid=%0b busy=%0b, want 0 0", capture_valid_o,
               busy_o);
    end
  endtask

  task automatic test_loopback();
    int spans[4];
    spans = '{1, 2, 4095, 65535};
    foreach (spans[i]) begin
      arm_once();
      tick(2);
      push_exp(spans[i]);
      drive_pulse(spans[i]);
      wait_valid("loopback");
      do_ack("loopback");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_high();
    test_saturation();
    test_handshake();
    test_restart();
    test_reset_mid();
    test_loopback();
    tick(3);
    checks++;
    if (q32.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q32.size(), q8.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
